// File: rtl/gf_serial_mult.sv
// ---------------------------------------------------------------------------
// gf_serial_mult
//
// Bit-serial GF(2^M) multiplier. It reduces modulo the fixed field polynomial
// POLY. It sits right after the GF(2^4) inverter in the ECC datapath. A
// typical job is forming the point-addition slope
//    lambda = (y1 ^ y2) * (x1 ^ x2)^-1
// where the inverter supplies the inverse on 'a'.
//
// The operands are captured when start is seen in IDLE. After that, one
// multiplier bit is consumed per clock, most significant bit first, using
// Horner's rule:
//    acc = acc * x + rb[i] * ra   (mod POLY)
// A result takes M clocks in RUN. The product is then presented on 'out'
// together with a one-cycle 'done' pulse. It stays on 'out' until the next
// completion or until reset.
//
// Optional feature (macro GF_MULT_ACC_EN):
//    When the macro is defined, an addend port 'c' exists. It is captured
//    with the operands and XORed into the final product, which gives a fused
//    multiply-add: out = (a*b mod POLY) ^ c. Latency is the same either way.
//    When the macro is undefined, neither 'c' nor its holding register exist.
//
// Parameters:
//    M        field degree; width of the operands and the result (M >= 2)
//    POLY     field polynomial, M+1 bits wide, with POLY[M] = 1
//             (default x^4 + x + 1)
//
// Ports:
//    clock    rising-edge clock
//    reset_n  asynchronous, active-low reset
//    start    request; only looked at while idle
//    a        multiplicand, reduced form
//    b        multiplier, reduced form
//    c        addend (GF_MULT_ACC_EN builds only)
//    busy     high while a multiplication is running
//    done     one-cycle pulse; 'out' is valid from this cycle on
//    out      product, held between completions
// ---------------------------------------------------------------------------
module gf_serial_mult #(
   parameter int         M    = 4,
   parameter logic [M:0] POLY = 5'b10011
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         start,
   input  logic [M-1:0] a,
   input  logic [M-1:0] b,
`ifdef GF_MULT_ACC_EN
   input  logic [M-1:0] c,
`endif
   output logic         busy,
   output logic         done,
   output logic [M-1:0] out
);

   // The bit counter only has to hold M-1 down to 0.
   localparam int CW = (M > 1) ? $clog2(M) : 1;

   localparam logic [0:0] STATE_IDLE = 1'b0;
   localparam logic [0:0] STATE_RUN  = 1'b1;

   // The reduction term is the polynomial without its leading x^M bit.
   // That bit is what falls off the top when acc is shifted.
   localparam logic [M-1:0] POLY_LOW = POLY[M-1:0];

   logic [0:0]    state;
   logic [M-1:0]  ra;
   logic [M-1:0]  rb;
   logic [M-1:0]  acc;
   logic [CW-1:0] cnt;

   logic [M-1:0]  acc_shift;
   logic [M-1:0]  acc_next;
   logic [M-1:0]  result;

`ifdef GF_MULT_ACC_EN
   logic [M-1:0]  rc;
`endif

   // One Horner step. Multiplying acc by x is a left shift. If the bit
   // shifted out was set, the x^M term it represents is replaced by its
   // residue POLY_LOW, which keeps acc reduced to M bits at every step. The
   // current multiplier bit then conditionally adds (XORs) the multiplicand.
   always_comb begin
      acc_shift = {acc[M-2:0], 1'b0};
      if (acc[M-1]) begin
         acc_shift = acc_shift ^ POLY_LOW;
      end
      acc_next = acc_shift;
      if (rb[cnt]) begin
         acc_next = acc_shift ^ ra;
      end
   end

   // The value written to 'out' on the last step. The final Horner step is
   // taken directly from acc_next, so no extra cycle is spent moving acc to
   // the output.
   always_comb begin
`ifdef GF_MULT_ACC_EN
      result = acc_next ^ rc;
`else
      result = acc_next;
`endif
   end

   // Control and datapath registers. IDLE waits for start and captures the
   // operands. RUN performs one step per clock until the counter has
   // consumed bit 0. At that point the product is written to 'out', done is
   // pulsed, and the FSM returns to IDLE. Returning to IDLE in the done
   // cycle is what allows a back-to-back start to be taken in that cycle.
   // Reset aborts everything immediately, with no done pulse.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= STATE_IDLE;
         ra    <= '0;
         rb    <= '0;
         acc   <= '0;
         cnt   <= '0;
         done  <= 1'b0;
         out   <= '0;
`ifdef GF_MULT_ACC_EN
         rc    <= '0;
`endif
      end else begin
         done <= 1'b0;
         if (state == STATE_IDLE) begin
            if (start) begin
               ra    <= a;
               rb    <= b;
`ifdef GF_MULT_ACC_EN
               rc    <= c;
`endif
               acc   <= '0;
               cnt   <= CW'(M - 1);
               state <= STATE_RUN;
            end
         end else begin
            acc <= acc_next;
            cnt <= cnt - CW'(1);
            if (cnt == '0) begin
               out   <= result;
               done  <= 1'b1;
               state <= STATE_IDLE;
            end
         end
      end
   end

   // busy follows the state directly. It rises after the start edge and
   // falls on the same edge that raises done.
   assign busy = (state == STATE_RUN);

endmodule

// File: tb/tb_gf_serial_mult.sv
// ---------------------------------------------------------------------------
// tb_gf_serial_mult
//
// Self-checking bench for gf_serial_mult with M=4 and POLY = x^4 + x + 1.
//
// The reference model forms the full carry-less product of a and b. It then
// reduces that product by long division with the field polynomial. When
// GF_MULT_ACC_EN is defined, the model also XORs in the addend.
//
// All inputs are driven and all outputs are sampled on the falling clock
// edge.
// ---------------------------------------------------------------------------
module tb_gf_serial_mult;

   localparam int         M    = 4;
   localparam logic [M:0] POLY = 5'b10011;

`ifdef GF_MULT_ACC_EN
   localparam bit ACC_EN = 1'b1;
`else
   localparam bit ACC_EN = 1'b0;
`endif

   logic         clock   = 1'b0;
   logic         reset_n = 1'b0;
   logic         start   = 1'b0;
   logic [M-1:0] a       = '0;
   logic [M-1:0] b       = '0;
   logic [M-1:0] c       = '0;
   logic         busy;
   logic         done;
   logic [M-1:0] out;

   int checkCount = 0;
   int passCount  = 0;

   gf_serial_mult #(.M(M), .POLY(POLY)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (start),
      .a       (a),
      .b       (b),
`ifdef GF_MULT_ACC_EN
      .c       (c),
`endif
      .busy    (busy),
      .done    (done),
      .out     (out)
   );

   // Free-running clock with a period of 10 time units.
   always #5 clock = ~clock;

   // Watchdog so that the run always ends, even if the design locks up.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model: schoolbook carry-less product followed by polynomial
   // long division, with the addend applied in multiply-add builds.
   function automatic logic [M-1:0] gfModel(input logic [M-1:0] x,
                                            input logic [M-1:0] y,
                                            input logic [M-1:0] z);
      int prod = 0;
      for (int i = 0; i < M; i++) begin
         if (y[i]) prod = prod ^ (int'(x) << i);
      end
      for (int k = 2*M-2; k >= M; k--) begin
         if (prod[k]) prod = prod ^ (int'(POLY) << (k - M));
      end
      return prod[M-1:0] ^ (ACC_EN ? z : '0);
   endfunction

   // Runs one multiplication and returns the observed results to the
   // caller. The operand inputs are scrambled right after the start edge,
   // so a design that reads them mid-operation produces a wrong product.
   // The task also records whether 'out' moved away from 'held' before
   // done arrived.
   task automatic runOp(input  logic [M-1:0] ia,
                        input  logic [M-1:0] ib,
                        input  logic [M-1:0] ic,
                        input  logic [M-1:0] held,
                        output logic [M-1:0] res,
                        output int           lat,
                        output int           busyCycles,
                        output bit           heldBad,
                        output bit           timedOut);
      @(negedge clock);
      a = ia; b = ib; c = ic; start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      a = M'($urandom); b = M'($urandom); c = M'($urandom);
      lat = 0; busyCycles = 0; heldBad = 1'b0; timedOut = 1'b0;
      while (done !== 1'b1) begin
         if (busy === 1'b1) busyCycles++;
         if (out !== held) heldBad = 1'b1;
         if (lat >= 20) begin
            timedOut = 1'b1;
            break;
         end
         @(negedge clock);
         lat++;
      end
      res = out;
   endtask

   // Checks the outputs both while reset is held and just after it is
   // released.
   task automatic test_reset();
      reset_n = 1'b0;
      #12;
      checkCount++;
      if ({busy, done, out} !== 6'b0) $display("[TB] FAIL reset_hold: busy/done/out=%b, required 000000", {busy, done, out});
      else passCount++;
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      checkCount++;
      if ({busy, done, out} !== 6'b0) $display("[TB] FAIL reset_release: busy/done/out=%b, required 000000", {busy, done, out});
      else passCount++;
   endtask

   // Checks the known spec vectors against constants, plus the latency, the
   // busy length, the done width and the hold on 'out'.
   task automatic test_known_vectors();
      logic [M-1:0] va [5] = '{4'h9, 4'h3, 4'h8, 4'hF, 4'h0};
      logic [M-1:0] vb [5] = '{4'h2, 4'h7, 4'h8, 4'hF, 4'hB};
      logic [M-1:0] vr [5] = '{4'h1, 4'h9, 4'hC, 4'hA, 4'h0};
      logic [M-1:0] prev = '0;
      logic [M-1:0] res;
      int lat, bc;
      bit hb, to;
      for (int i = 0; i < 5; i++) begin
         runOp(va[i], vb[i], 4'h0, prev, res, lat, bc, hb, to);
         checkCount++;
         if (to || res !== vr[i]) $display("[TB] FAIL known_%0d: out=%h (timeout=%0d), required %h", i, res, to, vr[i]);
         else passCount++;
         checkCount++;
         if (hb) $display("[TB] FAIL hold_%0d: out changed before done, required %h held", i, prev);
         else passCount++;
         if (i == 0) begin
            checkCount++;
            if (lat !== 4) $display("[TB] FAIL latency: done %0d edges after start edge, required 4", lat);
            else passCount++;
            checkCount++;
            if (bc !== 4) $display("[TB] FAIL busy_len: busy for %0d cycles, required 4", bc);
            else passCount++;
         end
         @(negedge clock);
         checkCount++;
         if (done !== 1'b0 || out !== vr[i]) $display("[TB] FAIL done_width_%0d: done=%b out=%h, required done=0 out=%h", i, done, out, vr[i]);
         else passCount++;
         prev = vr[i];
      end
`ifdef GF_MULT_ACC_EN
      runOp(4'h9, 4'h2, 4'h6, prev, res, lat, bc, hb, to);
      checkCount++;
      if (to || res !== 4'h7) $display("[TB] FAIL fused_add: out=%h, required 7", res);
      else passCount++;
`endif
   endtask

   // Sweeps every a and b against the model. A random addend is used,
   // which only matters in multiply-add builds.
   task automatic test_exhaustive();
      logic [M-1:0] res, exp, prev;
      int lat, bc;
      bit hb, to;
      prev = out;
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            logic [M-1:0] cc;
            cc  = M'($urandom);
            exp = gfModel(M'(i), M'(j), cc);
            runOp(M'(i), M'(j), cc, prev, res, lat, bc, hb, to);
            checkCount++;
            if (to || hb || res !== exp)
               $display("[TB] FAIL sweep a=%h b=%h c=%h: out=%h (timeout=%0d hold_bad=%0d), required %h", i[3:0], j[3:0], cc, res, to, hb, exp);
            else passCount++;
            prev = res;
         end
      end
   endtask

   // Holds start high. A new operation should be accepted in every done
   // cycle, giving a done pulse every 5 cycles. The operands are scrambled
   // in every cycle that is not a done cycle.
   task automatic test_back_to_back();
      logic [M-1:0] exp;
      int gap, dones;
      @(negedge clock);
      a = M'($urandom); b = M'($urandom); c = M'($urandom);
      exp = gfModel(a, b, c);
      start = 1'b1;
      gap = 0; dones = 0;
      for (int cyc = 0; cyc < 80 && dones < 8; cyc++) begin
         @(posedge clock);
         @(negedge clock);
         gap++;
         if (done === 1'b1) begin
            checkCount++;
            if (out !== exp) $display("[TB] FAIL b2b_result_%0d: out=%h, required %h", dones, out, exp);
            else passCount++;
            checkCount++;
            if (gap !== 5) $display("[TB] FAIL b2b_period_%0d: period=%0d, required 5", dones, gap);
            else passCount++;
            dones++;
            gap = 0;
            if (dones == 8) start = 1'b0;
            else begin
               a = M'($urandom); b = M'($urandom); c = M'($urandom);
               exp = gfModel(a, b, c);
            end
         end else begin
            a = M'($urandom); b = M'($urandom); c = M'($urandom);
         end
      end
      start = 1'b0;
      checkCount++;
      if (dones !== 8) $display("[TB] FAIL b2b_count: %0d done pulses, required 8", dones);
      else passCount++;
      @(negedge clock);
      @(negedge clock);
      checkCount++;
      if (busy !== 1'b0) $display("[TB] FAIL b2b_drain: busy=%b, required 0", busy);
      else passCount++;
   endtask

   // Pulls reset low in the second RUN cycle. The outputs should clear at
   // once, and no done pulse should follow until a new start.
   task automatic test_reset_mid_op();
      logic [M-1:0] res;
      int lat, bc;
      bit hb, to, sawDone;
      runOp(4'h9, 4'h2, 4'h0, out, res, lat, bc, hb, to);
      checkCount++;
      if (to || res !== 4'h1) $display("[TB] FAIL pre_abort: out=%h, required 1", res);
      else passCount++;
      @(negedge clock);
      a = 4'h5; b = 4'h6; c = 4'h0; start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      checkCount++;
      if ({busy, done, out} !== 6'b0) $display("[TB] FAIL abort_clear: busy/done/out=%b, required 000000", {busy, done, out});
      else passCount++;
      @(negedge clock);
      reset_n = 1'b1;
      sawDone = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (done === 1'b1 || busy === 1'b1) sawDone = 1'b1;
      end
      checkCount++;
      if (sawDone) $display("[TB] FAIL abort_quiet: activity seen after abort, required none");
      else passCount++;
      runOp(4'h5, 4'h6, 4'h3, 4'h0, res, lat, bc, hb, to);
      checkCount++;
      if (to || hb || res !== gfModel(4'h5, 4'h6, 4'h3)) $display("[TB] FAIL post_abort: out=%h, required %h", res, gfModel(4'h5, 4'h6, 4'h3));
      else passCount++;
   endtask

   initial begin
      $display("[TB] gf_serial_mult bench, ACC_EN=%0d", ACC_EN);
      test_reset();
      test_known_vectors();
      test_exhaustive();
      test_back_to_back();
      test_reset_mid_op();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
